// File: rtl/clk_burst_ctrl.sv
// Burst controller for a half-period clock divider: issues 2*burst_len trig2x
// pulses spaced div_val cycles apart, with a glitch-free (even-count) abort.
module clk_burst_ctrl (
    input  logic        CLK50MHZ,
    input  logic        RST,
    input  logic        start,
    input  logic        stop,
    input  logic [15:0] div_val,
    input  logic [7:0]  burst_len,
    output logic        trig2x,
    output logic        level,
    output logic        busy,
    output logic        done
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [15:0] r_div_m1;
    logic [7:0]  r_burst_m1;
    logic [15:0] r_presc;
    logic [8:0]  r_half_cnt;
    logic        r_level;
    logic        r_stop_pend;
    logic        r_done;

    logic        w_accept;
    logic        w_trig;
    logic        w_last;
    logic        w_abort;
    logic        w_end;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case
        // leaves it unassigned, which would otherwise infer a latch.
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_trig       = 1'b0;
        w_last       = 1'b0;
        w_abort      = 1'b0;
        w_end        = 1'b0;
        case (r_state)
            S_IDLE: begin
                // The done cycle still belongs to the finished burst.
                w_accept = start && !r_done;
                if (w_accept) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                w_trig  = (r_presc == r_div_m1);
                // Final pulse is number 2*burst_lat, i.e. index 2*burst_lat-1.
                w_last  = w_trig && (r_half_cnt == {r_burst_m1, 1'b1});
                // Abort only on a pulse that brings level back to 0.
                w_abort = w_trig && r_level && (r_stop_pend || stop);
                w_end   = w_last || w_abort;
                if (w_end) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK50MHZ) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge CLK50MHZ) begin
        if (RST) begin
            r_div_m1    <= '0;
            r_burst_m1  <= '0;
            r_presc     <= '0;
            r_half_cnt  <= '0;
            r_level     <= 1'b0;
            r_stop_pend <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= (r_state == S_RUN) && w_end;
            if (w_accept) begin
                // 0 encodes 1 for div_val; burst_len-1 wraps 0 to 255 (=256 bursts).
                r_div_m1    <= (div_val == 16'd0) ? 16'd0 : div_val - 16'd1;
                r_burst_m1  <= burst_len - 8'd1;
                r_presc     <= '0;
                r_half_cnt  <= '0;
                r_level     <= 1'b0;
                r_stop_pend <= 1'b0;
            end else if (r_state == S_RUN) begin
                if (w_end) begin
                    r_presc     <= '0;
                    r_half_cnt  <= '0;
                    r_level     <= 1'b0;
                    r_stop_pend <= 1'b0;
                end else begin
                    if (stop) begin
                        r_stop_pend <= 1'b1;
                    end
                    if (w_trig) begin
                        r_presc    <= '0;
                        r_half_cnt <= r_half_cnt + 9'd1;
                        r_level    <= ~r_level;
                    end else begin
                        r_presc <= r_presc + 16'd1;
                    end
                end
            end
        end
    end

    // level shows the divider state after the pulse of the current cycle.
    assign trig2x = w_trig;
    assign level  = r_level ^ w_trig;
    assign busy   = (r_state == S_RUN);
    assign done   = r_done;

endmodule

// File: tb/tb_clk_burst_ctrl.sv
// Directed bench for clk_burst_ctrl. Busy cycles are numbered b1, b2, ... with
// b1 the first cycle busy is high; pulse n of a div_lat burst lands in b(n*div_lat).
module tb_clk_burst_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic [15:0] div_val;
    logic [7:0]  burst_len;
    logic        trig2x;
    logic        level;
    logic        busy;
    logic        done;

    int total    = 0;
    int bad      = 0;
    int trig_cnt = 0;
    int done_cnt = 0;
    int n;

    clk_burst_ctrl dut (
        .CLK50MHZ  (clk),
        .RST       (rst),
        .start     (start),
        .stop      (stop),
        .div_val   (div_val),
        .burst_len (burst_len),
        .trig2x    (trig2x),
        .level     (level),
        .busy      (busy),
        .done      (done)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (trig2x === 1'b1) trig_cnt++;
        if (done === 1'b1) done_cnt++;
    end

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in b1 of the new burst.
    task automatic launch(input logic [15:0] d, input logic [7:0] l);
        div_val   = d;
        burst_len = l;
        start     = 1'b1;
        trig_cnt  = 0;
        done_cnt  = 0;
        tick;
        start     = 1'b0;
    endtask

    // Called in busy cycle 'from'; returns total busy length, stops in the done cycle.
    task automatic run_out(input int budget, input int from, output int len);
        len = from - 1;
        while (busy === 1'b1 && len < budget) begin
            len++;
            tick;
        end
        if (busy === 1'b1) check_bit("run_timeout", busy, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b1;
        stop      = 1'b1;
        div_val   = 16'd4;
        burst_len = 8'd2;
        repeat (3) tick;
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_trig", trig2x, 1'b0);
        check_bit("rst_level", level, 1'b0);
        check_bit("rst_done", done, 1'b0);

        // Basic burst, start in the first cycle after reset; ignored start at b6.
        rst = 1'b0;
        stop = 1'b0;
        launch(16'd4, 8'd2);
        for (int k = 1; k <= 16; k++) begin
            check_bit($sformatf("basic_busy_b%0d", k), busy, 1'b1);
            check_bit($sformatf("basic_trig_b%0d", k), trig2x, (k % 4) == 0);
            check_bit($sformatf("basic_level_b%0d", k), level, ((k / 4) % 2) == 1);
            start   = (k == 6);
            div_val = (k == 6) ? 16'd1 : 16'd4;
            tick;
        end
        start = 1'b0;
        check_bit("basic_end_busy", busy, 1'b0);
        check_bit("basic_end_done", done, 1'b1);
        check_bit("basic_end_level", level, 1'b0);
        check_bit("basic_end_trig", trig2x, 1'b0);
        check_int("basic_pulses", trig_cnt, 4);

        // Start in the done cycle is ignored, accepted one cycle later.
        div_val   = 16'd2;
        burst_len = 8'd1;
        start     = 1'b1;
        tick;
        check_bit("done_start_ignored", busy, 1'b0);
        check_bit("done_single", done, 1'b0);
        check_int("done_count", done_cnt, 1);
        tick;
        start    = 1'b0;
        trig_cnt = 0;
        done_cnt = 0;
        check_bit("late_start_busy", busy, 1'b1);
        run_out(20, 1, n);
        check_int("late_len", n, 4);
        check_int("late_pulses", trig_cnt, 2);
        check_bit("late_done", done, 1'b1);

        // Stop in IDLE is ignored.
        tick;
        stop = 1'b1;
        tick;
        stop = 1'b0;
        check_bit("idle_stop_busy", busy, 1'b0);
        check_bit("idle_stop_done", done, 1'b0);
        launch(16'd2, 8'd1);
        run_out(20, 1, n);
        check_int("idle_stop_len", n, 4);
        check_int("idle_stop_pulses", trig_cnt, 2);

        // Zero encodings: 512 back-to-back pulses.
        tick;
        launch(16'd0, 8'd0);
        check_bit("zero_first_trig", trig2x, 1'b1);
        run_out(600, 1, n);
        check_int("zero_len", n, 512);
        check_int("zero_pulses", trig_cnt, 512);
        check_bit("zero_done", done, 1'b1);

        // Abort: stop coincides with the 2nd pulse (b6) of a div=3 burst.
        tick;
        launch(16'd3, 8'd10);
        repeat (5) tick;
        stop = 1'b1;
        check_bit("abort_trig_b6", trig2x, 1'b1);
        check_bit("abort_level_b6", level, 1'b0);
        tick;
        stop = 1'b0;
        check_bit("abort_busy", busy, 1'b0);
        check_bit("abort_done", done, 1'b1);
        check_bit("abort_level", level, 1'b0);
        check_int("abort_pulses", trig_cnt, 2);
        tick;
        check_bit("abort_done_off", done, 1'b0);
        check_int("abort_done_count", done_cnt, 1);

        // Stop on the final pulse of a normal burst.
        launch(16'd2, 8'd1);
        repeat (3) tick;
        stop = 1'b1;
        check_bit("last_trig_b4", trig2x, 1'b1);
        tick;
        stop = 1'b0;
        check_bit("last_busy", busy, 1'b0);
        check_bit("last_done", done, 1'b1);
        check_int("last_pulses", trig_cnt, 2);
        tick;
        check_bit("last_done_off", done, 1'b0);
        check_int("last_done_count", done_cnt, 1);

        // Stop during a high phase (b5) waits for the pulse at b8.
        launch(16'd4, 8'd3);
        repeat (4) tick;
        stop = 1'b1;
        tick;
        stop = 1'b0;
        run_out(40, 6, n);
        check_int("pend_hi_len", n, 8);
        check_int("pend_hi_pulses", trig_cnt, 2);

        // Stop during a low phase (b9) skips the pulse at b12, ends at b16.
        tick;
        launch(16'd4, 8'd3);
        repeat (8) tick;
        stop = 1'b1;
        check_bit("pend_lo_level_b9", level, 1'b0);
        tick;
        stop = 1'b0;
        run_out(40, 10, n);
        check_int("pend_lo_len", n, 16);
        check_int("pend_lo_pulses", trig_cnt, 4);

        // Reset after the 3rd pulse of an 8-pulse burst.
        tick;
        launch(16'd2, 8'd4);
        repeat (5) tick;
        check_bit("mid_trig3_b6", trig2x, 1'b1);
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check_bit("mid_rst_busy", busy, 1'b0);
        check_bit("mid_rst_trig", trig2x, 1'b0);
        check_bit("mid_rst_level", level, 1'b0);
        check_bit("mid_rst_done", done, 1'b0);
        tick;
        check_bit("mid_rst_no_done", done, 1'b0);
        check_int("mid_rst_done_count", done_cnt, 0);
        launch(16'd2, 8'd1);
        check_bit("post_rst_busy", busy, 1'b1);
        check_bit("post_rst_trig_b1", trig2x, 1'b0);
        tick;
        check_bit("post_rst_trig_b2", trig2x, 1'b1);
        check_bit("post_rst_level_b2", level, 1'b1);
        run_out(20, 2, n);
        check_int("post_rst_len", n, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
